// File: rtl/and_join_pkg.sv
// Shared types and default sizing for the two-operand AND join controller.
package and_join_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HAVE_A = 2'd1,
        HAVE_B = 2'd2,
        BOTH   = 2'd3
    } join_state_t;

    localparam int DEF_WIDTH   = 2;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TIMEOUT = 16;

    // The hold flags are exactly the two state bits.
    function automatic logic state_has_a(input join_state_t s);
        return (s == HAVE_A) || (s == BOTH);
    endfunction

    function automatic logic state_has_b(input join_state_t s);
        return (s == HAVE_B) || (s == BOTH);
    endfunction

    function automatic join_state_t state_from_holds(input logic ha, input logic hb);
        join_state_t s;
        case ({ha, hb})
            2'b10:   s = HAVE_A;
            2'b01:   s = HAVE_B;
            2'b11:   s = BOTH;
            default: s = IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/and_join_wait_timer.sv
// Partner-starvation timer: saturating wait counter plus sticky stall_err.
// Latency: stall_err rises on the edge the count reaches TIMEOUT.
// Backpressure: none; purely observational, never stalls the join.
module and_join_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic err_clr,
    output logic stall_err
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
    localparam logic [TW-1:0] TPRE = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt;
    logic          reach_evt;

    // One-cycle pulse on the edge where the count steps onto TIMEOUT.
    assign reach_evt = en && !clr && (cnt == TPRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != TMAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A new timeout outranks a simultaneous clear request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_err <= 1'b0;
        end else if (reach_evt) begin
            stall_err <= 1'b1;
        end else if (err_clr) begin
            stall_err <= 1'b0;
        end
    end

endmodule

// File: rtl/and_join_ctrl.sv
// Joins one operand from each of two requesters and emits opA & opB into a registered slot.
// Latency: both handshakes in cycle t give out_valid in cycle t+2; one result per cycle sustained.
// Backpressure: out_ready low holds the slot; a full BOTH pair then drops a_ready/b_ready.
module and_join_ctrl
    import and_join_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic             stall_err,
    input  logic             err_clr
);

    join_state_t      state_q, state_d;
    logic             hold_a, hold_b;
    logic             fire;
    logic             a_hs, b_hs;
    logic             out_hs;
    logic             wait_en;
    logic [WIDTH-1:0] opa, opb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Readies depend only on held state and out_ready, never on the valids.
    always_comb begin
        hold_a  = state_has_a(state_q);
        hold_b  = state_has_b(state_q);
        fire    = (state_q == BOTH) && (!out_valid || out_ready);
        a_ready = !hold_a || fire;
        b_ready = !hold_b || fire;
        a_hs    = a_valid && a_ready;
        b_hs    = b_valid && b_ready;
        state_d = state_from_holds((hold_a && !fire) || a_hs,
                                   (hold_b && !fire) || b_hs);
        wait_en = (state_q == HAVE_A) || (state_q == HAVE_B);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa <= '0;
            opb <= '0;
        end else begin
            if (a_hs) opa <= a_data;
            if (b_hs) opb <= b_data;
        end
    end

    assign out_hs = out_valid && out_ready;

    // A fire on the same edge as a drain refills the slot, giving back-to-back results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_data  <= opa & opb;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (out_hs) begin
            op_count <= op_count + 1'b1;
        end
    end

    assign busy = hold_a || hold_b || out_valid;

    and_join_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (wait_en),
        .clr       (!wait_en),
        .err_clr   (err_clr),
        .stall_err (stall_err)
    );

endmodule

// File: tb/tb_and_join_ctrl.sv
// Directed bench for and_join_ctrl: join, starvation, backpressure, streaming wrap, async reset.
module tb_and_join_ctrl;

    localparam int WIDTH   = 2;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             a_valid, b_valid, out_ready, err_clr;
    logic [WIDTH-1:0] a_data, b_data;
    logic             a_ready, b_ready, out_valid, busy, stall_err;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] op_count;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    and_join_ctrl #(
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_data    (b_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .op_count  (op_count),
        .stall_err (stall_err),
        .err_clr   (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [WIDTH-1:0] ad,
                         input logic bv, input logic [WIDTH-1:0] bd);
        a_valid = av;
        a_data  = ad;
        b_valid = bv;
        b_data  = bd;
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] ea, eb;
        rst_n = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 2'b00);
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_op_count", op_count, 0);
        check("rst_stall_err", stall_err, 0);
        check("rst_busy", busy, 0);
        check("rst_a_ready", a_ready, 1);
        check("rst_b_ready", b_ready, 1);
        rst_n = 1'b1;
        tick();

        // Basic join: 11 & 01 = 01, two cycles later.
        drive(1'b1, 2'b11, 1'b1, 2'b01);
        tick();
        drive(1'b0, 2'b00, 1'b0, 2'b00);
        check("join_t1_out_valid", out_valid, 0);
        check("join_t1_busy", busy, 1);
        tick();
        check("join_t2_out_valid", out_valid, 1);
        check("join_t2_out_data", out_data, 2'b01);
        check("join_t2_op_count", op_count, 0);
        tick();
        check("join_hs_op_count", op_count, 1);
        check("join_hs_out_valid", out_valid, 0);
        check("join_hs_busy", busy, 0);

        // Starvation: A held alone for TIMEOUT cycles.
        drive(1'b1, 2'b11, 1'b0, 2'b00);
        tick();
        drive(1'b0, 2'b00, 1'b0, 2'b00);
        check("stall_a_ready_held", a_ready, 0);
        check("stall_b_ready", b_ready, 1);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check("stall_before_timeout", stall_err, 0);
        tick();
        check("stall_at_timeout", stall_err, 1);
        drive(1'b0, 2'b00, 1'b1, 2'b10);
        tick();
        drive(1'b0, 2'b00, 1'b0, 2'b00);
        tick();
        check("stall_join_valid", out_valid, 1);
        check("stall_join_data", out_data, 2'b10);
        tick();
        check("stall_join_count", op_count, 2);
        check("stall_err_sticky", stall_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("stall_err_cleared", stall_err, 0);

        // Backpressure with three back-to-back pairs.
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 1'b1, 2'b11);
        tick();
        drive(1'b1, 2'b10, 1'b1, 2'b11);
        check("bp_ready_while_firing", a_ready, 1);
        tick();
        drive(1'b1, 2'b01, 1'b1, 2'b11);
        check("bp_first_valid", out_valid, 1);
        check("bp_first_data", out_data, 2'b11);
        check("bp_a_ready_blocked", a_ready, 0);
        check("bp_b_ready_blocked", b_ready, 0);
        tick();
        check("bp_first_stable", out_data, 2'b11);
        check("bp_a_ready_still_blocked", a_ready, 0);
        out_ready = 1'b1;
        #1;
        check("bp_ready_via_out_ready", a_ready, 1);
        tick();
        drive(1'b0, 2'b00, 1'b0, 2'b00);
        check("bp_second_data", out_data, 2'b10);
        check("bp_second_valid", out_valid, 1);
        tick();
        check("bp_third_data", out_data, 2'b01);
        check("bp_third_valid", out_valid, 1);
        tick();
        check("bp_drained_valid", out_valid, 0);
        check("bp_drained_count", op_count, 5);
        check("bp_drained_busy", busy, 0);

        // Stream 256 pairs from a zero count; count must wrap back to zero.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        check("stream_start_count", op_count, 0);
        for (int k = 0; k < 259; k++) begin
            if (k < 256) drive(1'b1, WIDTH'(k), 1'b1, WIDTH'(k >> 2));
            else         drive(1'b0, 2'b00, 1'b0, 2'b00);
            if (k >= 2 && k < 258) begin
                ea = WIDTH'(k - 2);
                eb = WIDTH'((k - 2) >> 2);
                check($sformatf("stream_valid_%0d", k - 2), out_valid, 1);
                check($sformatf("stream_data_%0d", k - 2), out_data, ea & eb);
            end
            if (k < 256) check($sformatf("stream_a_ready_%0d", k), a_ready, 1);
            if (k == 257) check("stream_count_pre_wrap", op_count, 255);
            if (k == 258) begin
                check("stream_count_wrapped", op_count, 0);
                check("stream_done_valid", out_valid, 0);
            end
            if (k < 258) tick();
        end

        // Async reset while in BOTH with a pending result.
        drive(1'b1, 2'b11, 1'b1, 2'b11);
        tick();
        drive(1'b0, 2'b00, 1'b0, 2'b00);
        tick();
        tick();
        check("arst_pre_count", op_count, 1);
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 1'b1, 2'b01);
        tick();
        drive(1'b1, 2'b10, 1'b1, 2'b10);
        tick();
        drive(1'b0, 2'b00, 1'b0, 2'b00);
        check("arst_pre_valid", out_valid, 1);
        check("arst_pre_ready_blocked", a_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_op_count", op_count, 0);
        check("arst_busy", busy, 0);
        check("arst_a_ready", a_ready, 1);
        out_ready = 1'b1;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("arst_no_stale_%0d", i), out_valid, 0);
        end
        check("arst_post_count", op_count, 0);

        // Timeout set and err_clr on the same edge: set wins.
        drive(1'b0, 2'b00, 1'b1, 2'b01);
        tick();
        drive(1'b0, 2'b00, 1'b0, 2'b00);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check("race_before", stall_err, 0);
        err_clr = 1'b1;
        tick();
        check("race_set_wins", stall_err, 1);
        tick();
        err_clr = 1'b0;
        check("race_clear_after", stall_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/and_join_ctrl.md
Name: and_join_ctrl

Overview:
- Controller that sequences the two-operand capture / AND / capture datapath.
- Two independent requesters each hand over one operand through valid/ready.
- The block joins the operand pair, issues one AND operation per pair into a registered output slot, and delivers the result downstream with backpressure.
- It also counts completed operations and flags a partner-starvation stall.

Parameters:
- WIDTH, 2, operand/result width in bits.
- CNT_W, 8, width of the completed-operation counter.
- TIMEOUT, 16, cycles one operand may wait for its partner before stall_err sets; must be >= 1.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  requester A operand valid.
- a_ready  output  1  block can accept operand A.
- a_data  input  WIDTH  operand A.
- b_valid  input  1  requester B operand valid.
- b_ready  output  1  block can accept operand B.
- b_data  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  result, opA & opB.
- busy  output  1  any operand held or result pending.
- op_count  output  CNT_W  completed output handshakes, modulo 2^CNT_W.
- stall_err  output  1  sticky starvation flag.
- err_clr  input  1  clears stall_err.

Behaviour:
- Reset: clk and rst_n are fixed as above (single clock, asynchronous active-low reset). While rst_n is low, all state clears immediately.
  - Registered outputs in reset: out_valid=0, out_data=0, op_count=0, stall_err=0, busy=0.
  - Combinational outputs in reset: a_ready=1 and b_ready=1, because the join FSM is in IDLE.
  - A reset in mid-operation discards held operands and any pending result. No partial result is ever emitted.
- Join FSM states (held flags hold_a, hold_b):
  - IDLE: nothing held.
  - HAVE_A: A held.
  - HAVE_B: B held.
  - BOTH: both held.
- FSM transitions:
  - An A handshake (a_valid & a_ready) loads opA and sets hold_a. B works the same way.
  - IDLE goes to HAVE_A, HAVE_B, or BOTH (simultaneous handshakes).
  - HAVE_A goes to BOTH on a B handshake. HAVE_B goes to BOTH on an A handshake.
  - BOTH goes to IDLE on fire. It stays in BOTH if a new handshake arrives on the same edge it fires.
- fire = BOTH & (!out_valid | out_ready).
  - On fire, out_data <= opA & opB, out_valid <= 1, and both hold flags clear unless reloaded that same edge.
- Ready rules:
  - a_ready = !hold_a | fire; b_ready = !hold_b | fire.
  - There is no combinational path from a_valid or b_valid to any ready.
  - A combinational path from out_ready to a_ready/b_ready is permitted.
- Latency and throughput:
  - Both handshakes in cycle t give out_valid=1 in cycle t+2 (hold in t+1, fire at the end of t+1).
  - Sustained throughput is one result per cycle when out_ready stays high.
- Output slot:
  - out_valid clears after an out_valid & out_ready edge unless fire reloads it.
  - out_data is stable while out_valid & !out_ready.
- op_count increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
- Wait timer:
  - Counts cycles spent in HAVE_A or HAVE_B and saturates at TIMEOUT.
  - Resets to 0 in IDLE or BOTH.
  - stall_err sets on the edge where the count reaches TIMEOUT.
  - err_clr clears stall_err. If set and clear occur in the same cycle, set wins.
- busy = hold_a | hold_b | out_valid.
- Operands are registered data only; their values never alter the sequencing.

Decomposition:
- Package and_join_pkg:
  - join_state_t enum {IDLE, HAVE_A, HAVE_B, BOTH}.
  - Default constants for WIDTH, CNT_W, TIMEOUT.
- One sub-module, and_join_wait_timer.
  - Saturating counter with enable (single-held state) and sync clear.
  - Reports a reached pulse, and owns the sticky stall_err with err_clr.
- The top level holds the FSM, operand registers, the output slot and op_count.

Test Plan:
- Reset release, then a_data=2'b11 and b_data=2'b01 both valid in cycle 1 with out_ready=1.
  - Required: out_valid=1 with out_data=2'b01 in cycle 3, op_count=1 after the handshake.
- A valid only, with b_valid low for TIMEOUT=16 cycles.
  - Required: a_ready=0 while held, stall_err=1 after 16 cycles.
  - Then B arrives with 2'b10 and A holds 2'b11: out_data=2'b10.
  - err_clr pulse: stall_err=0.
- out_ready=0 with three operand pairs offered back-to-back.
  - Required: the first result is held stable, the second pair is held in BOTH, and a_ready=b_ready=0.
  - Raising out_ready: results drain in order, one per cycle, with no loss.
- Streaming 256 pairs with out_ready=1 and CNT_W=8.
  - Required: one result per cycle after the 2-cycle fill, and op_count wraps to 0.
- rst_n asserted asynchronously (mid-cycle) while in BOTH with out_valid=1.
  - Required: out_valid=0 and op_count=0 immediately, no stale result emitted after rst_n rises.
- err_clr high in the same cycle the timer reaches TIMEOUT.
  - Required: stall_err=1 (set wins).
